pgm_irq_ctrl: RTL and testbench

- Parametrised 68000 interrupt controller for the PGM core.
- Latches up to NUM_SRC interrupt requests (vblank, timers, sound-CPU mailbox, ...) and priority-encodes them onto ipl_n.
- Detects the 68000 interrupt-acknowledge (IACK) cycle and answers it with autovector vpa_n. Clears the acknowledged source.
- Sits between the video/timer/sound blocks and the fx68k ipl_n/vpa_n pins, which are currently tied inactive.

---
 rtl/pgm_irq_ctrl.sv | 133 +++++++++++++
 tb/tb_pgm_irq_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pgm_irq_ctrl.sv
// 68000 interrupt controller for the PGM core: latches requests, priority-encodes
// them onto ipl_n and answers the IACK cycle with an autovector (vpa_n).
module pgm_irq_ctrl #(
  parameter int                     NUM_SRC   = 4,
  parameter logic [3*NUM_SRC-1:0]   SRC_LEVEL = {3'd6, 3'd4, 3'd2, 3'd1},
  parameter logic [NUM_SRC-1:0]     SRC_EDGE  = {NUM_SRC{1'b1}}
) (
  input  logic               fixed_20m_clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               irq_enable_we,
  input  logic [NUM_SRC-1:0] irq_enable_din,
  input  logic               irq_clr_we,
  input  logic [NUM_SRC-1:0] irq_clr_din,
  input  logic [2:0]         cpu_fc,
  input  logic [2:0]         cpu_addr,
  input  logic               cpu_as_n,
  output logic [2:0]         ipl_n,
  output logic               vpa_n,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic [NUM_SRC-1:0] irq_ack
);

  localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_SRC-1:0] r_pending, r_enable, r_prev, r_irq_ack;
  logic [2:0]         r_ipl_n;
  logic               r_vpa_n, w_vpa_n_nxt;
  logic               r_as_prev;
  logic [IDXW-1:0]    r_ack_src, w_match_src;
  logic               r_ack_valid, w_match_valid;
  logic [NUM_SRC-1:0] w_active, w_set, w_clr, w_ack_onehot;
  logic [2:0]         w_win_level;
  logic               w_iack_start;

  assign w_active     = r_pending & r_enable;
  assign w_iack_start = (cpu_fc == 3'b111) && !cpu_as_n && r_as_prev;
  assign w_ack_onehot = (r_state == ST_ACK && r_ack_valid) ? (NUM_SRC'(1) << r_ack_src)
                                                           : '0;

  // Edge sources fire on a 0->1 transition, level sources every high cycle.
  assign w_set = irq_src & (~SRC_EDGE | ~r_prev);
  assign w_clr = (irq_clr_we ? irq_clr_din : '0) | w_ack_onehot;

  // Strict '>' keeps the lowest index on ties and never lets a level-0 source win.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_win_level = 3'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_active[i] && (SRC_LEVEL[3*i +: 3] > w_win_level))
        w_win_level = SRC_LEVEL[3*i +: 3];
    end
  end

  // Scan downward so the last hit is the lowest-indexed source at the asked level.
  always_comb begin
    w_match_src   = '0;
    w_match_valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_active[i] && (SRC_LEVEL[3*i +: 3] == cpu_addr) && (cpu_addr != 3'd0)) begin
        w_match_src   = IDXW'(i);
        w_match_valid = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vpa_n_nxt = r_vpa_n;
    case (r_state)
      ST_IDLE: begin
        w_vpa_n_nxt = 1'b1;
        if (w_iack_start) w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        w_vpa_n_nxt = 1'b0;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (cpu_as_n) begin
          w_vpa_n_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_vpa_n_nxt = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge fixed_20m_clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_pending   <= '0;
      r_enable    <= '0;
      r_prev      <= '0;
      r_irq_ack   <= '0;
      r_ipl_n     <= 3'b111;
      r_vpa_n     <= 1'b1;
      r_as_prev   <= 1'b1;
      r_ack_src   <= '0;
      r_ack_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_vpa_n   <= w_vpa_n_nxt;
      r_prev    <= irq_src;
      r_as_prev <= cpu_as_n;
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_irq_ack <= w_ack_onehot;
      r_ipl_n   <= ~w_win_level;
      if (irq_enable_we) r_enable <= irq_enable_din;
      if (r_state == ST_IDLE && w_iack_start) begin
        r_ack_src   <= w_match_src;
        r_ack_valid <= w_match_valid;
      end
    end
  end

  assign ipl_n       = r_ipl_n;
  assign vpa_n       = r_vpa_n;
  assign irq_pending = r_pending;
  assign irq_ack     = r_irq_ack;

endmodule

// File: tb/tb_pgm_irq_ctrl.sv
// Directed bench for pgm_irq_ctrl: a table of per-cycle vectors with hand-computed
// expectations, followed by a hand-written IACK handshake sequence.
module tb_pgm_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] irq_src, irq_enable_din, irq_clr_din;
  logic       irq_enable_we, irq_clr_we;
  logic [2:0] cpu_fc, cpu_addr;
  logic       cpu_as_n;
  logic [2:0] ipl_n;
  logic       vpa_n;
  logic [3:0] irq_pending, irq_ack;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pgm_irq_ctrl dut (
    .fixed_20m_clk (clk),
    .reset_n       (reset_n),
    .irq_src       (irq_src),
    .irq_enable_we (irq_enable_we),
    .irq_enable_din(irq_enable_din),
    .irq_clr_we    (irq_clr_we),
    .irq_clr_din   (irq_clr_din),
    .cpu_fc        (cpu_fc),
    .cpu_addr      (cpu_addr),
    .cpu_as_n      (cpu_as_n),
    .ipl_n         (ipl_n),
    .vpa_n         (vpa_n),
    .irq_pending   (irq_pending),
    .irq_ack       (irq_ack)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] src;
    logic       en_we;
    logic [3:0] en;
    logic       clr_we;
    logic [3:0] clr;
    logic [2:0] fc;
    logic [2:0] addr;
    logic       as_n;
    logic [2:0] exp_ipl;
    logic       exp_vpa;
    logic [3:0] exp_pend;
    logic [3:0] exp_ack;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] s, input logic ew, input logic [3:0] e,
                     input logic cw, input logic [3:0] c, input logic [2:0] f,
                     input logic [2:0] a, input logic asn, input logic [2:0] xi,
                     input logic xv, input logic [3:0] xp, input logic [3:0] xa);
    vec_t v;
    v.rst_n = r;  v.src = s;  v.en_we = ew; v.en = e; v.clr_we = cw; v.clr = c;
    v.fc = f; v.addr = a; v.as_n = asn;
    v.exp_ipl = xi; v.exp_vpa = xv; v.exp_pend = xp; v.exp_ack = xa;
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    reset_n = 1'b1; irq_src = '0; irq_enable_we = 1'b0; irq_enable_din = '0;
    irq_clr_we = 1'b0; irq_clr_din = '0; cpu_fc = '0; cpu_addr = '0; cpu_as_n = 1'b1;
  endtask

  // One active edge, then settle before outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   rst src   ew en     cw clr    fc  addr as | ipl vpa pend   ack
    add(0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd7, 1, 4'h0, 4'h0); // reset
    add(0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd7, 1, 4'h0, 4'h0);
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd7, 1, 4'h0, 4'h0); // idle
    add(1, 4'h0, 1, 4'h1, 0, 4'h0, 0, 0, 1, 3'd7, 1, 4'h0, 4'h0); // enable src0
    add(1, 4'h1, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd7, 1, 4'h1, 4'h0); // edge latch
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd6, 1, 4'h1, 4'h0); // ipl lags one cycle
    add(1, 4'h1, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd6, 1, 4'h1, 4'h0); // second pulse
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd6, 1, 4'h1, 4'h0);
    add(1, 4'h9, 1, 4'hF, 0, 4'h0, 0, 0, 1, 3'd6, 1, 4'h9, 4'h0); // src0+src3
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd1, 1, 4'h9, 4'h0); // L6 wins
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 7, 6, 0, 3'd1, 1, 4'h9, 4'h0); // IACK L6
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 7, 6, 0, 3'd1, 0, 4'h1, 4'h8); // vpa, ack src3
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 7, 6, 0, 3'd6, 0, 4'h1, 4'h0); // hold
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 7, 6, 1, 3'd6, 1, 4'h1, 4'h0); // AS rises
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd6, 1, 4'h1, 4'h0);
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 7, 5, 0, 3'd6, 1, 4'h1, 4'h0); // spurious L5
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 7, 5, 0, 3'd6, 0, 4'h1, 4'h0);
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 7, 5, 1, 3'd6, 1, 4'h1, 4'h0);
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd6, 1, 4'h1, 4'h0);
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 2, 1, 0, 3'd6, 1, 4'h1, 4'h0); // non-IACK bus cycle
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 2, 1, 0, 3'd6, 1, 4'h1, 4'h0);
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd6, 1, 4'h1, 4'h0);
    add(1, 4'h2, 0, 4'h0, 1, 4'h2, 0, 0, 1, 3'd6, 1, 4'h3, 4'h0); // set beats clear
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd5, 1, 4'h3, 4'h0);
    add(1, 4'h0, 0, 4'h0, 1, 4'h2, 0, 0, 1, 3'd5, 1, 4'h1, 4'h0); // software clear
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd6, 1, 4'h1, 4'h0);
    add(1, 4'h0, 1, 4'h0, 0, 4'h0, 0, 0, 1, 3'd6, 1, 4'h1, 4'h0); // disable all
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd7, 1, 4'h1, 4'h0); // pending kept
    add(1, 4'h0, 1, 4'hF, 0, 4'h0, 0, 0, 1, 3'd7, 1, 4'h1, 4'h0);
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd6, 1, 4'h1, 4'h0);
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 7, 1, 0, 3'd6, 1, 4'h1, 4'h0); // IACK L1
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 7, 1, 0, 3'd6, 0, 4'h0, 4'h1);
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 7, 1, 0, 3'd7, 0, 4'h0, 4'h0); // in HOLD
    add(0, 4'h0, 0, 4'h0, 0, 4'h0, 7, 1, 0, 3'd7, 1, 4'h0, 4'h0); // reset mid-HOLD
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 3'd7, 1, 4'h0, 4'h0);

    idle_inputs();
    reset_n = 1'b0;
    #2;

    foreach (vq[k]) begin
      reset_n        = vq[k].rst_n;
      irq_src        = vq[k].src;
      irq_enable_we  = vq[k].en_we;
      irq_enable_din = vq[k].en;
      irq_clr_we     = vq[k].clr_we;
      irq_clr_din    = vq[k].clr;
      cpu_fc         = vq[k].fc;
      cpu_addr       = vq[k].addr;
      cpu_as_n       = vq[k].as_n;
      step();
      check($sformatf("v%0d ipl_n", k),       32'(ipl_n),       32'(vq[k].exp_ipl));
      check($sformatf("v%0d vpa_n", k),       32'(vpa_n),       32'(vq[k].exp_vpa));
      check($sformatf("v%0d irq_pending", k), 32'(irq_pending), 32'(vq[k].exp_pend));
      check($sformatf("v%0d irq_ack", k),     32'(irq_ack),     32'(vq[k].exp_ack));
    end

    // Hand sequence: L4 source acknowledged, vpa_n latency measured with a bounded wait.
    begin
      int n;
      int ack_seen;
      idle_inputs();
      irq_enable_we = 1'b1; irq_enable_din = 4'b0100;
      step();
      irq_enable_we = 1'b0; irq_src = 4'b0100;
      step();
      irq_src = 4'b0000;
      step();
      check("seq ipl_n L4", 32'(ipl_n), 32'(3'b011));
      cpu_fc = 3'b111; cpu_addr = 3'd4; cpu_as_n = 1'b0;
      n = 0;
      ack_seen = 0;
      while (n < 6) begin
        step();
        n++;
        if (irq_ack == 4'b0100) ack_seen++;
        if (vpa_n == 1'b0) break;
      end
      check("seq vpa_n latency", 32'(n), 32'd2);
      check("seq irq_ack at vpa", 32'(irq_ack), 32'(4'b0100));
      check("seq pending cleared", 32'(irq_pending), 32'(4'b0000));
      step();
      if (irq_ack == 4'b0100) ack_seen++;
      check("seq irq_ack pulse count", 32'(ack_seen), 32'd1);
      check("seq vpa_n held", 32'(vpa_n), 32'd0);
      step();
      check("seq vpa_n still held", 32'(vpa_n), 32'd0);
      cpu_as_n = 1'b1;
      step();
      check("seq vpa_n release", 32'(vpa_n), 32'd1);
      check("seq ipl_n idle", 32'(ipl_n), 32'(3'b111));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
